axi_csr_bridge: RTL and testbench

AXI_CSR_BRIDGE -- requirements
Module: axi_csr_bridge

---
 rtl/axi_csr_bridge_pkg.sv | 33 +++
 rtl/axi_csr_bridge.sv | 194 +++++++++++++++++++
 tb/tb_axi_csr_bridge.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_csr_bridge_pkg.sv
// Shared types for the AXI-to-CSR bridge: CSR request/response structs,
// the bridge FSM state encoding and the AXI response codes it emits.
package axi_csr_bridge_pkg;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;

   typedef struct packed {
      logic        valid;
      logic        rd_or_wr;   // 1 = write, 0 = read
      logic [15:0] addr;
      logic [31:0] data_in;
   } s_csr_req_t;

   typedef struct packed {
      logic        ready;
      logic        error;
      logic [31:0] data_out;
   } s_csr_resp_t;

   typedef enum logic [3:0] {
      IDLE,
      WR_DATA,
      WR_DRAIN,
      WR_CSR,
      WR_RESP,
      RD_CSR,
      RD_CAP,
      RD_RESP,
      RD_ERR
   } csr_bridge_st_t;

endpackage

// File: rtl/axi_csr_bridge.sv
// AXI4 slave front-end for the CSR block: one transaction in flight, single-beat CSR access,
// bursts answered with SLVERR. Define RAVENOC_CSR_RD_PRIO_EN to make reads win AW/AR contention.
module axi_csr_bridge
   import axi_csr_bridge_pkg::*;
#(
   parameter int ID_WIDTH = 8
) (
   input  logic                clk_axi,
   input  logic                arst_axi,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ID_WIDTH-1:0] awid,
   input  logic [31:0]         awaddr,
   input  logic [7:0]          awlen,
   input  logic                wvalid,
   output logic                wready,
   input  logic [31:0]         wdata,
   input  logic                wlast,
   output logic                bvalid,
   input  logic                bready,
   output logic [ID_WIDTH-1:0] bid,
   output logic [1:0]          bresp,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ID_WIDTH-1:0] arid,
   input  logic [31:0]         araddr,
   input  logic [7:0]          arlen,
   output logic                rvalid,
   input  logic                rready,
   output logic [ID_WIDTH-1:0] rid,
   output logic [31:0]         rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output s_csr_req_t          csr_req_o,
   input  s_csr_resp_t         csr_resp_i
);

`ifdef RAVENOC_CSR_RD_PRIO_EN
   localparam logic RD_PRIO = 1'b1;
`else
   localparam logic RD_PRIO = 1'b0;
`endif

   // Handshakes: a beat transfers on the rising edge where valid && ready;
   // once raised, the bridge holds valid and its payload until that edge.
   csr_bridge_st_t       state;
   logic                 ptr_wr;
   logic [ID_WIDTH-1:0]  id_q;
   logic [15:0]          addr_q;
   logic [7:0]           len_q;
   logic [7:0]           beat_q;
   logic                 grant_wr;
   logic                 grant_rd;
   logic                 unused_addr_hi;

   // CSR space is 64 KiB; upper address bits select the bridge upstream.
   assign unused_addr_hi = ^{awaddr[31:16], araddr[31:16]};

   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (state == IDLE) begin
         if (awvalid && arvalid) begin
            grant_rd = RD_PRIO || !ptr_wr;
            grant_wr = !grant_rd;
         end else begin
            grant_wr = awvalid;
            grant_rd = arvalid;
         end
      end
   end

   assign awready = grant_wr;
   assign arready = grant_rd;
   assign wready  = (state == WR_DATA) || (state == WR_DRAIN);

   always_ff @(posedge clk_axi) begin
      if (arst_axi) begin
         state     <= IDLE;
         ptr_wr    <= 1'b1;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         bvalid    <= 1'b0;
         bid       <= '0;
         bresp     <= AXI_OKAY;
         rvalid    <= 1'b0;
         rid       <= '0;
         rdata     <= '0;
         rresp     <= AXI_OKAY;
         rlast     <= 1'b0;
         csr_req_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_wr) begin
                  ptr_wr <= 1'b0;
                  id_q   <= awid;
                  addr_q <= awaddr[15:0];
                  state  <= (awlen == 8'd0) ? WR_DATA : WR_DRAIN;
               end else if (grant_rd) begin
                  ptr_wr <= 1'b1;
                  id_q   <= arid;
                  len_q  <= arlen;
                  beat_q <= '0;
                  if (arlen == 8'd0) begin
                     csr_req_o.valid    <= 1'b1;
                     csr_req_o.rd_or_wr <= 1'b0;
                     csr_req_o.addr     <= araddr[15:0];
                     state              <= RD_CSR;
                  end else begin
                     // Bursts are not supported: answer every beat with SLVERR.
                     rvalid <= 1'b1;
                     rid    <= arid;
                     rdata  <= '0;
                     rresp  <= AXI_SLVERR;
                     rlast  <= 1'b0;
                     state  <= RD_ERR;
                  end
               end
            end
            WR_DATA: begin
               if (wvalid) begin
                  csr_req_o.valid    <= 1'b1;
                  csr_req_o.rd_or_wr <= 1'b1;
                  csr_req_o.addr     <= addr_q;
                  csr_req_o.data_in  <= wdata;
                  state              <= WR_CSR;
               end
            end
            WR_DRAIN: begin
               if (wvalid && wlast) begin
                  bvalid <= 1'b1;
                  bid    <= id_q;
                  bresp  <= AXI_SLVERR;
                  state  <= WR_RESP;
               end
            end
            WR_CSR: begin
               if (csr_resp_i.ready) begin
                  csr_req_o.valid <= 1'b0;
                  bvalid          <= 1'b1;
                  bid             <= id_q;
                  bresp           <= csr_resp_i.error ? AXI_SLVERR : AXI_OKAY;
                  state           <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (bready) begin
                  bvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            RD_CSR: begin
               if (csr_resp_i.ready) begin
                  csr_req_o.valid <= 1'b0;
                  state           <= RD_CAP;
               end
            end
            RD_CAP: begin
               // Responder presents read data exactly one cycle after accepting the request.
               rdata  <= csr_resp_i.data_out;
               rresp  <= csr_resp_i.error ? AXI_SLVERR : AXI_OKAY;
               rvalid <= 1'b1;
               rlast  <= 1'b1;
               rid    <= id_q;
               state  <= RD_RESP;
            end
            RD_RESP: begin
               if (rready) begin
                  rvalid <= 1'b0;
                  rlast  <= 1'b0;
                  state  <= IDLE;
               end
            end
            RD_ERR: begin
               if (rready) begin
                  if (beat_q == len_q) begin
                     rvalid <= 1'b0;
                     rlast  <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     beat_q <= beat_q + 8'd1;
                     rlast  <= ((beat_q + 8'd1) == len_q);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_csr_bridge.sv
// Randomized scoreboard bench for axi_csr_bridge with a behavioural CSR responder;
// honours RAVENOC_CSR_RD_PRIO_EN for the expected arbitration order.
`timescale 1ns/1ps
module tb_axi_csr_bridge;
   import axi_csr_bridge_pkg::*;

   localparam logic [15:0] OFF_VERSION     = 16'h0000;
   localparam logic [15:0] OFF_IRQ_RD_MASK = 16'h0008;
   localparam logic [15:0] OFF_UNMAPPED    = 16'h0FFC;
   localparam logic [31:0] RAVENOC_LABEL   = 32'h7261_7665;
   localparam logic [31:0] UNMAPPED_DATA   = 32'hDEAD_BEEF;
   localparam int          BUDGET          = 4000;

   logic        clk = 1'b0;
   logic        arst;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [7:0]  awid, arid, bid, rid, awlen, arlen;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [1:0]  bresp, rresp;
   s_csr_req_t  csr_req;
   s_csr_resp_t csr_resp;

   int n_checks = 0;
   int n_fails  = 0;

   // scoreboard entry: {is_rd, id[7:0], data[31:0], resp[1:0], last}
   logic [43:0] exp_q[$];
   // CSR request entry: {rd_or_wr, addr[15:0], data[31:0]}
   logic [48:0] csr_q[$];
   logic [31:0] model_regs[int];
   bit          model_ptr_wr;
   bit          force_ready;

   axi_csr_bridge #(.ID_WIDTH(8)) dut (
      .clk_axi(clk), .arst_axi(arst),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .csr_req_o(csr_req), .csr_resp_i(csr_resp)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      n_fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit wr_error(input logic [15:0] off);
      return (off >= 16'h0100) || (off == OFF_VERSION);
   endfunction

   function automatic logic [43:0] pack_rsp(input logic is_rd, input logic [7:0] id,
                                            input logic [31:0] data, input logic [1:0] resp,
                                            input logic last);
      return {is_rd, id, data, resp, last};
   endfunction

   task automatic model_write(input logic [7:0] id, input logic [15:0] off,
                              input logic [7:0] len, input logic [31:0] data);
      if (len == 8'd0) begin
         csr_q.push_back({1'b1, off, data});
         if (!wr_error(off)) model_regs[int'(off)] = data;
         exp_q.push_back(pack_rsp(1'b0, id, 32'h0, wr_error(off) ? 2'b10 : 2'b00, 1'b0));
      end else begin
         exp_q.push_back(pack_rsp(1'b0, id, 32'h0, 2'b10, 1'b0));
      end
      model_ptr_wr = 1'b0;
   endtask

   task automatic model_read(input logic [7:0] id, input logic [15:0] off, input logic [7:0] len);
      logic [31:0] d;
      if (len == 8'd0) begin
         csr_q.push_back({1'b0, off, 32'h0});
         if (off == OFF_VERSION)           d = RAVENOC_LABEL;
         else if (off >= 16'h0100)         d = UNMAPPED_DATA;
         else if (model_regs.exists(int'(off))) d = model_regs[int'(off)];
         else                              d = 32'h0;
         exp_q.push_back(pack_rsp(1'b1, id, d, (off >= 16'h0100) ? 2'b10 : 2'b00, 1'b1));
      end else begin
         for (int b = 0; b <= int'(len); b++)
            exp_q.push_back(pack_rsp(1'b1, id, 32'h0, 2'b10, b == int'(len)));
      end
      model_ptr_wr = 1'b1;
   endtask

   // ---------------- CSR responder + request monitor ----------------
   logic [31:0] csr_regs [0:63];
   bit          rd_pend;
   logic [15:0] rd_addr;
   bit          csr_hs_prev;
   logic [48:0] c_ent;

   always @(negedge clk) begin
      csr_resp.error    = 1'b0;
      csr_resp.data_out = $urandom;
      if (rd_pend) begin
         rd_pend = 1'b0;
         if (rd_addr >= 16'h0100) begin
            csr_resp.data_out = UNMAPPED_DATA;
            csr_resp.error    = 1'b1;
         end else begin
            csr_resp.data_out = csr_regs[rd_addr[7:2]];
         end
      end
      csr_resp.ready = force_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (csr_hs_prev) check("csr_valid_drops", csr_req.valid, 1'b0);
      csr_hs_prev = csr_req.valid && csr_resp.ready;
      if (csr_req.valid && csr_resp.ready) begin
         if (csr_req.rd_or_wr) begin
            csr_resp.error = (csr_req.addr >= 16'h0100) || (csr_req.addr == 16'h0000);
            if (!csr_resp.error) csr_regs[csr_req.addr[7:2]] = csr_req.data_in;
         end else begin
            rd_pend = 1'b1;
            rd_addr = csr_req.addr;
         end
         if (csr_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL csr_unexpected: request addr 0x%0h with nothing expected", csr_req.addr);
         end else begin
            c_ent = csr_q.pop_front();
            check("csr_dir", csr_req.rd_or_wr, c_ent[48]);
            check("csr_addr", csr_req.addr, c_ent[47:32]);
            if (c_ent[48]) check("csr_data_in", csr_req.data_in, c_ent[31:0]);
         end
      end
   end

   // ---------------- response monitor ----------------
   logic [43:0] e_ent;
   bit          b_hold, r_hold;
   logic [9:0]  b_snap;
   logic [42:0] r_snap;

   always @(negedge clk) begin
      bready = ($urandom_range(0, 2) != 0);
      rready = $urandom_range(0, 1);
      if (bvalid || rvalid) check("b_r_exclusive", bvalid && rvalid, 1'b0);
      if (b_hold) check("b_stable", {bvalid, bid, bresp}, {1'b1, b_snap});
      if (r_hold) check("r_stable", {rvalid, rid, rdata, rresp, rlast}, {1'b1, r_snap});
      if (bvalid && bready) begin
         if (exp_q.size() == 0) begin
            n_checks++; n_fails++;
            $display("FAIL b_unexpected: bid 0x%0h bresp %0b with nothing expected", bid, bresp);
         end else begin
            e_ent = exp_q.pop_front();
            check("b_kind", 1'b0, e_ent[43]);
            check("bid", bid, e_ent[42:35]);
            check("bresp", bresp, e_ent[2:1]);
         end
      end
      if (rvalid && rready) begin
         if (exp_q.size() == 0) begin
            n_checks++; n_fails++;
            $display("FAIL r_unexpected: rid 0x%0h rdata 0x%0h with nothing expected", rid, rdata);
         end else begin
            e_ent = exp_q.pop_front();
            check("r_kind", 1'b1, e_ent[43]);
            check("rid", rid, e_ent[42:35]);
            check("rdata", rdata, e_ent[34:3]);
            check("rresp", rresp, e_ent[2:1]);
            check("rlast", rlast, e_ent[0]);
         end
      end
      b_hold = bvalid && !bready;
      b_snap = {bid, bresp};
      r_hold = rvalid && !rready;
      r_snap = {rid, rdata, rresp, rlast};
   end

   // ---------------- driver tasks ----------------
   function automatic logic ready_of(input int ch);
      case (ch)
         0:       return awready;
         1:       return wready;
         default: return arready;
      endcase
   endfunction

   // Called at a negedge with the channel's valid already raised; returns at the negedge after the transfer.
   task automatic wait_ready(input int ch, input string name);
      int n = 0;
      forever begin
         #1;
         if (ready_of(ch)) break;
         if (n >= BUDGET) begin
            n_checks++; n_fails++;
            $display("FAIL %s_timeout: ready not seen within %0d cycles", name, BUDGET);
            break;
         end
         n++;
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
      awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
      wait_ready(0, "aw");
      awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [7:0] len, input logic [31:0] data);
      for (int b = 0; b <= int'(len); b++) begin
         wvalid = 1'b1;
         wdata  = (b == 0) ? data : $urandom;
         wlast  = (len == 8'd0) ? 1'($urandom_range(0, 1)) : (b == int'(len));
         wait_ready(1, "w");
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
      arvalid = 1'b1; arid = id; araddr = addr; arlen = len;
      wait_ready(2, "ar");
      arvalid = 1'b0;
   endtask

   task automatic issue_write(input logic [7:0] id, input logic [15:0] off,
                              input logic [7:0] len, input logic [31:0] data);
      model_write(id, off, len, data);
      aw_send(id, {16'($urandom), off}, len);
      w_send(len, data);
   endtask

   task automatic issue_read(input logic [7:0] id, input logic [15:0] off, input logic [7:0] len);
      model_read(id, off, len);
      ar_send(id, {16'($urandom), off}, len);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || csr_q.size() != 0) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", exp_q.size() + csr_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   // AW and AR raised on the same cycle; expected order follows the arbitration rule.
   task automatic issue_pair(input logic [15:0] woff, input logic [15:0] roff);
      bit          rd_first;
      logic [7:0]  wid, rid_l;
      logic [31:0] wd;
      wid = 8'($urandom); rid_l = 8'($urandom); wd = $urandom;
      drain();
`ifdef RAVENOC_CSR_RD_PRIO_EN
      rd_first = 1'b1;
`else
      rd_first = !model_ptr_wr;
`endif
      if (rd_first) begin
         model_read(rid_l, roff, 8'd0);
         model_write(wid, woff, 8'd0, wd);
      end else begin
         model_write(wid, woff, 8'd0, wd);
         model_read(rid_l, roff, 8'd0);
      end
      fork
         begin aw_send(wid, {16'h4000, woff}, 8'd0); w_send(8'd0, wd); end
         begin ar_send(rid_l, {16'h4000, roff}, 8'd0); end
      join
      drain();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_handshakes"}, {awready, arready, wready, bvalid, rvalid, rlast}, 6'b0);
      check({tag, "_ids"}, {bid, rid}, 16'h0);
      check({tag, "_resps"}, {bresp, rresp}, 4'b0);
      check({tag, "_rdata"}, rdata, 32'h0);
      check({tag, "_csr_req"}, csr_req, 50'h0);
   endtask

   // ---------------- main sequence ----------------
   logic [7:0]  t_id;
   logic [15:0] t_off;
   logic [7:0]  t_len;
   int          sel;

   initial begin
      arst = 1'b1;
      awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0;
      wvalid = 1'b0; wdata = '0; wlast = 1'b0;
      arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0;
      force_ready = 1'b0;
      model_ptr_wr = 1'b1;
      for (int i = 0; i < 64; i++) csr_regs[i] = 32'h0;
      csr_regs[0] = RAVENOC_LABEL;
      repeat (3) @(negedge clk);
      #1;
      check_reset_values("por");
      @(negedge clk);
      arst = 1'b0;

      force_ready = 1'b1;
      issue_write(8'h5A, OFF_IRQ_RD_MASK, 8'd0, 32'h0000_00F0);
      issue_read(8'hC3, OFF_VERSION, 8'd0);
      drain();
      force_ready = 1'b0;
      issue_write(8'h11, OFF_VERSION, 8'd0, 32'h1234_5678);
      issue_read(8'h22, OFF_UNMAPPED, 8'd0);
      issue_read(8'h33, OFF_IRQ_RD_MASK, 8'd0);
      issue_read(8'h44, OFF_IRQ_RD_MASK, 8'd3);
      issue_write(8'h55, 16'h0010, 8'd2, 32'hAAAA_5555);
      issue_write(8'h56, OFF_UNMAPPED, 8'd0, 32'h0BAD_0BAD);
      issue_read(8'h66, 16'h0020, 8'd255);
      drain();

      for (int p = 0; p < 4; p++) issue_pair(16'(16'h0040 + p * 4), OFF_IRQ_RD_MASK);

      for (int t = 0; t < 60; t++) begin
         t_id = 8'($urandom);
         sel  = $urandom_range(0, 9);
         if (sel == 0)      t_off = OFF_VERSION;
         else if (sel == 1) t_off = OFF_UNMAPPED;
         else               t_off = 16'($urandom_range(1, 63) * 4);
         t_len = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 5)) : 8'd0;
         if ($urandom_range(0, 1) == 1) issue_write(t_id, t_off, t_len, $urandom);
         else                           issue_read(t_id, t_off, t_len);
      end
      drain();

      // reset while draining a write burst
      aw_send(8'h77, 32'h0000_0030, 8'd3);
      check("drain_wready", wready, 1'b1);
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      #1;
      check_reset_values("rst_wr_drain");
      model_ptr_wr = 1'b1;
      repeat (6) @(negedge clk);

      // reset while the read data is being captured
      force_ready = 1'b1;
      csr_q.push_back({1'b0, OFF_IRQ_RD_MASK, 32'h0});
      ar_send(8'h88, {16'h0000, OFF_IRQ_RD_MASK}, 8'd0);
      check("rd_csr_valid", csr_req.valid, 1'b1);
      @(negedge clk);
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      #1;
      check_reset_values("rst_rd_cap");
      model_ptr_wr = 1'b1;
      force_ready = 1'b0;
      repeat (6) @(negedge clk);

      issue_pair(16'h0050, 16'h0050);
      issue_pair(16'h0054, OFF_VERSION);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
